// File: rtl/alioth_exu_pkg.sv
// alioth_exu_pkg: shared FSM states, op encoding and special-case results for the muldiv unit
package alioth_exu_pkg;
  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
  typedef enum logic [2:0] {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU} op_t;
  localparam logic [31:0] DIV0_QUO = 32'hFFFF_FFFF;
  localparam logic [31:0] OVF_QUO  = 32'h8000_0000;
  localparam logic [31:0] OVF_REM  = 32'h0000_0000;
endpackage

// File: rtl/exu_div_iter.sv
// exu_div_iter: radix-2 restoring divider on magnitudes, one quotient bit per cycle over 32 cycles
module exu_div_iter (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        kill,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic        done,
  output logic [31:0] quo,
  output logic [31:0] rem
);
  logic        run;
  logic [4:0]  cnt;
  logic [31:0] quo_q, rem_q, dvs_q;
  logic [32:0] sh;
  logic        ge;
  assign sh   = {rem_q, quo_q[31]};
  assign ge   = sh >= {1'b0, dvs_q};
  // quo/rem are the values after the current step, so the final step can be consumed on the same edge
  assign rem  = ge ? 32'(sh - {1'b0, dvs_q}) : sh[31:0];
  assign quo  = {quo_q[30:0], ge};
  assign done = run && cnt == 5'd31;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run   <= 1'b0;
      cnt   <= '0;
      quo_q <= '0;
      rem_q <= '0;
      dvs_q <= '0;
    end else if (kill) begin
      run <= 1'b0;
      cnt <= '0;
    end else if (start) begin
      run   <= 1'b1;
      cnt   <= '0;
      quo_q <= dividend;
      rem_q <= '0;
      dvs_q <= divisor;
    end else if (run) begin
      quo_q <= quo;
      rem_q <= rem;
      cnt   <= cnt + 5'd1;
      run   <= !done;
    end
  end
endmodule

// File: rtl/exu_muldiv.sv
// exu_muldiv: RV32M multiply/divide unit; 2-cycle multiplier, 33-cycle iterative divider,
// single-cycle divide-by-zero / overflow results, result held until writeback accepts it
module exu_muldiv
  import alioth_exu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        req_muldiv_i,
  input  logic [31:0] muldiv_op1_i,
  input  logic [31:0] muldiv_op2_i,
  input  logic        muldiv_op_mul_i,
  input  logic        muldiv_op_mulh_i,
  input  logic        muldiv_op_mulhsu_i,
  input  logic        muldiv_op_mulhu_i,
  input  logic        muldiv_op_div_i,
  input  logic        muldiv_op_divu_i,
  input  logic        muldiv_op_rem_i,
  input  logic        muldiv_op_remu_i,
  input  logic [4:0]  reg_waddr_i,
  input  logic        flush_i,
  input  logic        result_ready_i,
  output logic        busy_o,
  output logic        result_valid_o,
  output logic [31:0] result_o,
  output logic [4:0]  reg_waddr_o
);
  state_t             state;
  op_t                op_in, op_q;
  logic [31:0]        op1_q, op2_q, special_res, div_res, mul_res, div_q, div_r;
  logic               is_div, sgn_div, is_rem, div0, ovf, special, div_start, div_done;
  logic               neg_q, neg_r;
  logic signed [32:0] a33, b33;
  logic [63:0]        prod;
  assign op_in = muldiv_op_mul_i    ? OP_MUL    :
                 muldiv_op_mulh_i   ? OP_MULH   :
                 muldiv_op_mulhsu_i ? OP_MULHSU :
                 muldiv_op_mulhu_i  ? OP_MULHU  :
                 muldiv_op_div_i    ? OP_DIV    :
                 muldiv_op_divu_i   ? OP_DIVU   :
                 muldiv_op_rem_i    ? OP_REM    :
                 muldiv_op_remu_i   ? OP_REMU   : OP_MUL;
  assign is_div      = op_in inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
  assign sgn_div     = op_in inside {OP_DIV, OP_REM};
  assign is_rem      = op_in inside {OP_REM, OP_REMU};
  assign div0        = muldiv_op2_i == '0;
  assign ovf         = sgn_div && muldiv_op1_i == 32'h8000_0000 && muldiv_op2_i == 32'hFFFF_FFFF;
  assign special     = is_div && (div0 || ovf);
  assign special_res = div0 ? (is_rem ? muldiv_op1_i : DIV0_QUO) : (is_rem ? OVF_REM : OVF_QUO);
  assign div_start   = state == IDLE && req_muldiv_i && !flush_i && is_div && !special;
  assign a33  = {(op_q == OP_MULH || op_q == OP_MULHSU) && op1_q[31], op1_q};
  assign b33  = {op_q == OP_MULH && op2_q[31], op2_q};
  // 64 bits of the sign-extended 33x33 product are exact for every mul variant
  assign prod    = 64'(a33) * 64'(b33);
  assign mul_res = op_q == OP_MUL ? prod[31:0] : prod[63:32];
  assign div_res = op_q inside {OP_REM, OP_REMU} ? (neg_r ? -div_r : div_r) : (neg_q ? -div_q : div_q);
  assign busy_o         = state != IDLE;
  assign result_valid_o = state == DONE;
  exu_div_iter u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (div_start),
    .kill     (flush_i),
    .dividend (sgn_div && muldiv_op1_i[31] ? -muldiv_op1_i : muldiv_op1_i),
    .divisor  (sgn_div && muldiv_op2_i[31] ? -muldiv_op2_i : muldiv_op2_i),
    .done     (div_done),
    .quo      (div_q),
    .rem      (div_r)
  );
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      op_q        <= OP_MUL;
      op1_q       <= '0;
      op2_q       <= '0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      result_o    <= '0;
      reg_waddr_o <= '0;
    end else if (flush_i) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: if (req_muldiv_i) begin
          op_q        <= op_in;
          op1_q       <= muldiv_op1_i;
          op2_q       <= muldiv_op2_i;
          reg_waddr_o <= reg_waddr_i;
          neg_q       <= sgn_div && (muldiv_op1_i[31] ^ muldiv_op2_i[31]);
          neg_r       <= sgn_div && muldiv_op1_i[31];
          state       <= !is_div ? MUL : special ? DONE : DIV;
          if (special) result_o <= special_res;
        end
        MUL: begin
          result_o <= mul_res;
          state    <= DONE;
        end
        DIV: if (div_done) begin
          result_o <= div_res;
          state    <= DONE;
        end
        DONE: if (result_ready_i) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_exu_muldiv.sv
// tb_exu_muldiv: randomized and directed checks of exu_muldiv against a plain-arithmetic model
module tb_exu_muldiv;
  logic        clk = 0, rst = 0, req = 0, flush = 0, ready = 0;
  logic [31:0] op1 = 0, op2 = 0;
  logic [7:0]  opsel = 0;
  logic [4:0]  waddr = 0;
  logic        busy, valid;
  logic [31:0] result;
  logic [4:0]  waddr_o;
  int          errors = 0, checks = 0;

  always #5 clk = ~clk;

  exu_muldiv dut (
    .clk(clk), .rst(rst), .req_muldiv_i(req),
    .muldiv_op1_i(op1), .muldiv_op2_i(op2),
    .muldiv_op_mul_i(opsel[0]), .muldiv_op_mulh_i(opsel[1]),
    .muldiv_op_mulhsu_i(opsel[2]), .muldiv_op_mulhu_i(opsel[3]),
    .muldiv_op_div_i(opsel[4]), .muldiv_op_divu_i(opsel[5]),
    .muldiv_op_rem_i(opsel[6]), .muldiv_op_remu_i(opsel[7]),
    .reg_waddr_i(waddr), .flush_i(flush), .result_ready_i(ready),
    .busy_o(busy), .result_valid_o(valid), .result_o(result), .reg_waddr_o(waddr_o)
  );

  // op index: 0 mul, 1 mulh, 2 mulhsu, 3 mulhu, 4 div, 5 divu, 6 rem, 7 remu
  function automatic logic [31:0] model(int op, logic [31:0] a, logic [31:0] b);
    logic [63:0] p;
    int sa, sb;
    bit o;
    sa = a;
    sb = b;
    o = a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
    case (op)
      0: return a * b;
      1: begin p = {{32{a[31]}}, a} * {{32{b[31]}}, b}; return p[63:32]; end
      2: begin p = {{32{a[31]}}, a} * {32'b0, b}; return p[63:32]; end
      3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        else if (o) return 32'h8000_0000;
        else return 32'(sa / sb);
      end
      5: begin
        if (b == 0) return 32'hFFFF_FFFF;
        else return a / b;
      end
      6: begin
        if (b == 0) return a;
        else if (o) return 32'h0;
        else return 32'(sa % sb);
      end
      default: begin
        if (b == 0) return a;
        else return a % b;
      end
    endcase
  endfunction

  function automatic int exp_lat(int op, logic [31:0] a, logic [31:0] b);
    if (op < 4) return 2;
    if (b == 0 || ((op == 4 || op == 6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) return 1;
    return 33;
  endfunction

  // Called #1 after a rising edge with the unit idle; lat counts the accept cycle as 1, -1 on timeout
  task automatic do_op(input int op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] w,
                       output logic [31:0] res, output logic [4:0] wo, output int lat);
    req = 1; opsel = 8'(1 << op); op1 = a; op2 = b; waddr = w;
    @(posedge clk); #1;
    req = 0; opsel = 0; lat = 1;
    while (!valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!valid) lat = -1;
    res = result; wo = waddr_o;
    ready = 1;
    @(posedge clk); #1;
    ready = 0;
  endtask

  task automatic test_reset();
    #2;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", valid); end
    checks++; if (result !== 32'h0) begin errors++; $display("FAIL reset_result: got %h want 0", result); end
    checks++; if (waddr_o !== 5'h0) begin errors++; $display("FAIL reset_waddr: got %h want 0", waddr_o); end
    @(posedge clk); #1;
    rst = 1;
  endtask

  task automatic test_directed();
    int          d_op[8]  = '{1, 3, 4, 6, 5, 7, 4, 6};
    logic [31:0] d_a[8]   = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'hFFFF_FFF9,
                              32'd100, 32'd100, 32'h8000_0000, 32'h8000_0000};
    logic [31:0] d_b[8]   = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2, 32'd2, 32'd0, 32'd0,
                              32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] d_exp[8] = '{32'h0, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'hFFFF_FFFF,
                              32'hFFFF_FFFF, 32'd100, 32'h8000_0000, 32'h0};
    int          d_lat[8] = '{2, 2, 33, 33, 1, 1, 1, 1};
    logic [31:0] res;
    logic [4:0]  wo;
    int          lat;
    for (int i = 0; i < 8; i++) begin
      do_op(d_op[i], d_a[i], d_b[i], 5'(i + 1), res, wo, lat);
      checks++; if (res !== d_exp[i]) begin errors++; $display("FAIL directed_result[%0d]: got %h want %h", i, res, d_exp[i]); end
      checks++; if (lat != d_lat[i]) begin errors++; $display("FAIL directed_latency[%0d]: got %0d want %0d", i, lat, d_lat[i]); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL directed_idle[%0d]: busy got %b want 0", i, busy); end
    end
  endtask

  task automatic test_random();
    logic [31:0] a, b, res;
    logic [4:0]  w, wo;
    int          op, lat, sel;
    for (int i = 0; i < 40; i++) begin
      op  = $urandom_range(0, 7);
      sel = $urandom_range(0, 9);
      a   = sel == 9 ? 32'h8000_0000 : $urandom;
      sel = $urandom_range(0, 9);
      b   = sel == 0 ? 32'h0 : sel == 1 ? $urandom_range(1, 15) : sel == 2 ? 32'hFFFF_FFFF : $urandom;
      if ($urandom_range(0, 3) == 0) a = {$urandom} & 32'h8000_FFFF;
      w   = 5'($urandom);
      do_op(op, a, b, w, res, wo, lat);
      checks++; if (res !== model(op, a, b)) begin errors++; $display("FAIL random_result op=%0d a=%h b=%h: got %h want %h", op, a, b, res, model(op, a, b)); end
      checks++; if (wo !== w) begin errors++; $display("FAIL random_waddr: got %h want %h", wo, w); end
      checks++; if (lat != exp_lat(op, a, b)) begin errors++; $display("FAIL random_latency op=%0d b=%h: got %0d want %0d", op, b, lat, exp_lat(op, a, b)); end
    end
  endtask

  task automatic test_backpressure();
    req = 1; opsel = 8'h01; op1 = 3; op2 = 5; waddr = 5'd13;
    @(posedge clk); #1;
    req = 0; opsel = 0; op1 = 0; waddr = 0;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      checks++; if (valid !== 1'b1) begin errors++; $display("FAIL hold_valid[%0d]: got %b want 1", i, valid); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL hold_busy[%0d]: got %b want 1", i, busy); end
      checks++; if (result !== 32'd15) begin errors++; $display("FAIL hold_result[%0d]: got %h want %h", i, result, 32'd15); end
      checks++; if (waddr_o !== 5'd13) begin errors++; $display("FAIL hold_waddr[%0d]: got %h want %h", i, waddr_o, 5'd13); end
      @(posedge clk); #1;
    end
    ready = 1;
    @(posedge clk); #1;
    ready = 0;
    checks++; if (busy !== 1'b0 || valid !== 1'b0) begin errors++; $display("FAIL hold_release: busy/valid got %b%b want 00", busy, valid); end
  endtask

  task automatic test_flush();
    req = 1; opsel = 8'h10; op1 = 32'd1000; op2 = 32'd7; waddr = 5'd3;
    @(posedge clk); #1;
    opsel = 8'h01; op1 = 6; op2 = 7; waddr = 5'd9;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      checks++; if (valid !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL flush_inflight[%0d]: busy/valid got %b%b want 10", i, busy, valid); end
    end
    flush = 1;
    @(posedge clk); #1;
    flush = 0;
    checks++; if (valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL flush_idle: busy/valid got %b%b want 00", busy, valid); end
    @(posedge clk); #1;
    req = 0; opsel = 0;
    checks++; if (busy !== 1'b1 || valid !== 1'b0) begin errors++; $display("FAIL flush_reaccept: busy/valid got %b%b want 10", busy, valid); end
    @(posedge clk); #1;
    checks++; if (valid !== 1'b1 || result !== 32'd42) begin errors++; $display("FAIL flush_newop: valid=%b result=%h want 1 %h", valid, result, 32'd42); end
    checks++; if (waddr_o !== 5'd9) begin errors++; $display("FAIL flush_newop_waddr: got %h want %h", waddr_o, 5'd9); end
    ready = 1;
    @(posedge clk); #1;
    ready = 0;
  endtask

  task automatic test_async_reset();
    logic [31:0] res;
    logic [4:0]  wo;
    int          lat;
    req = 1; opsel = 8'h10; op1 = 32'd1000; op2 = 32'd7; waddr = 5'd17;
    @(posedge clk); #1;
    req = 0; opsel = 0;
    repeat (5) @(posedge clk);
    #3;
    rst = 0;
    #1;
    checks++; if (busy !== 1'b0 || valid !== 1'b0) begin errors++; $display("FAIL arst_ctrl: busy/valid got %b%b want 00", busy, valid); end
    checks++; if (result !== 32'h0 || waddr_o !== 5'h0) begin errors++; $display("FAIL arst_data: result=%h waddr=%h want 0 0", result, waddr_o); end
    @(posedge clk); #1;
    rst = 1;
    do_op(0, 32'd2, 32'd2, 5'd5, res, wo, lat);
    checks++; if (res !== 32'd4) begin errors++; $display("FAIL arst_mul: got %h want %h", res, 32'd4); end
    checks++; if (lat != 2) begin errors++; $display("FAIL arst_mul_latency: got %0d want 2", lat); end
  endtask

  task automatic test_back_to_back();
    req = 1; opsel = 8'h01; op1 = 7; op2 = 8; waddr = 5'd1;
    @(posedge clk); #1;
    opsel = 8'h08; op1 = 32'hFFFF_FFFF; op2 = 2; waddr = 5'd2;
    @(posedge clk); #1;
    checks++; if (valid !== 1'b1 || result !== 32'd56) begin errors++; $display("FAIL b2b_first: valid=%b result=%h want 1 %h", valid, result, 32'd56); end
    ready = 1;
    @(posedge clk); #1;
    ready = 0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_no_same_cycle_accept: busy got %b want 0", busy); end
    @(posedge clk); #1;
    req = 0; opsel = 0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_accept: busy got %b want 1", busy); end
    @(posedge clk); #1;
    checks++; if (valid !== 1'b1 || result !== 32'd1 || waddr_o !== 5'd2) begin errors++; $display("FAIL b2b_second: valid=%b result=%h waddr=%h want 1 1 2", valid, result, waddr_o); end
    ready = 1;
    @(posedge clk); #1;
    ready = 0;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_flush();
    test_async_reset();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
